s32x_sdr_responder: RTL
=======================

// Module: s32x_sdr_responder
// PURPOSE
// Memory-side responder for the 32X SH-2 SDRAM port (SDR_A/SDR_DO/SDR_CS/SDR_WE/SDR_RD/SDR_WAIT/SDR_DI).
// Detects each SH-2 access and drives SDR_WAIT and SDR_DI so the core-side WAIT/latch logic
// (USE_SDR_WAIT=1) starts and completes it. Converts accesses to a req/ack handshake on a generic
// backend (SDRAM controller or BRAM). Optional 1-word write-through read cache skips backend on hits.
// PARAMETERS
// MIN_WAIT   2  min cycles SDR_WAIT held high per access (>=2: core samples start only on CE_F, every 2nd CLK)
// USE_CACHE  1  1 = enable 1-entry read cache; 0 = every read goes to backend
// PORTS
// CLK       in   1   system clock (same as 32X core CLK)
// RST_N     in   1   async active-low reset
// SDR_A     in   17  word address [17:1] from core
// SDR_DO    in   16  write data from core
// SDR_CS    in   1   access select, high active
// SDR_WE    in   2   byte write enables {upper,lower}, high active
// SDR_RD    in   1   read strobe, high active
// SDR_WAIT  out  1   busy; falling edge = access complete, SDR_DI valid
// SDR_DI    out  16  read data to core
// MEM_REQ   out  1   backend request, level, held until MEM_ACK
// MEM_WE    out  1   1 = write, 0 = read
// MEM_A     out  17  backend word address
// MEM_DO    out  16  backend write data
// MEM_BE    out  2   backend byte enables
// MEM_DI    in   16  backend read data, valid with MEM_ACK
// MEM_ACK   in   1   backend completion, 1-cycle pulse
// BEHAVIOUR
// Reset (async): SDR_WAIT=0, SDR_DI=0, MEM_REQ=0, MEM_WE=0, MEM_A=0, MEM_DO=0, MEM_BE=0; cache invalid; FSM=IDLE.
// Access active (ACT) = SDR_CS & (SDR_RD | SDR_WE!=0). Write wins if SDR_RD and SDR_WE both set.
// FSM: IDLE, REQ, HOLD, DONE.
// IDLE: on ACT, register A/DO/WE/RD into capture regs; SDR_WAIT=1 next cycle; load hold counter=MIN_WAIT-1.
//   Read hit (USE_CACHE, valid, tag==A) -> HOLD with SDR_DI<=cache data; else -> REQ.
// REQ: MEM_REQ=1 with captured A/DO/BE (BE=WE for write, 2'b11 for read). On MEM_ACK: MEM_REQ=0 same
//   edge; read: SDR_DI<=MEM_DI, cache<=(A,MEM_DI,valid); write: if cache tag==A merge bytes per WE -> HOLD.
//   MEM_ACK outside REQ is ignored.
// HOLD: hold counter decrements every cycle from IDLE exit, also while in REQ; leave HOLD when counter==0
//   -> SDR_WAIT=0, go DONE. Net SDR_WAIT high = max(MIN_WAIT, backend latency+1) cycles.
// DONE: SDR_WAIT=0, SDR_DI held. Return to IDLE when ACT drops. New access without ACT drop (SDR_A,
//   SDR_WE or SDR_RD differs from capture) is treated as new: capture, SDR_WAIT=1, as from IDLE.
// SDR_DI changes only on data load (REQ ack or hit); stable from SDR_WAIT fall until next access completes.
// Inputs sampled only in IDLE/DONE; changes during REQ/HOLD are ignored (core holds them stable).
// Reset mid-access: MEM_REQ drops immediately; any in-flight MEM_ACK after reset release is ignored.
// USE_CACHE=0: no tag compare, every read -> REQ; cache regs optimised out.
// Writes never allocate into the cache; only update an already-valid matching entry.
// TESTING
// Read miss: ACT read A=0x00100, MEM_ACK 4 cyc after MEM_REQ, MEM_DI=0xBEEF -> SDR_WAIT high 5 cyc, SDR_DI=0xBEEF at fall.
// Read hit: repeat read A=0x00100 (after ACT drop) -> no MEM_REQ, SDR_WAIT high exactly MIN_WAIT cyc, SDR_DI=0xBEEF.
// Byte write: WE=2'b10, DO=0x12xx to 0x00100 -> MEM_BE=10, MEM_WE=1; next read hits, SDR_DI=0x12EF.
// Held strobe: ACT held 20 cyc after completion -> exactly one MEM_REQ; then A changes to 0x00101 -> second access.
// Fast backend: MEM_ACK 1 cyc after MEM_REQ, MIN_WAIT=2 -> SDR_WAIT still high >=2 cyc; stray MEM_ACK in IDLE ignored.
// Reset during REQ: RST_N low -> MEM_REQ/SDR_WAIT 0 async; post-reset read of 0x00100 misses (cache invalid).

Source files
------------

// File: rtl/s32x_sdr_responder_if.sv
// Bus bundle between the 32X SH-2 SDRAM port, the responder and a generic
// memory backend.
//
// Handshake semantics:
//   Core side: an access is requested while SDR_CS & (SDR_RD | SDR_WE!=0).
//   The core holds SDR_A/SDR_DO/SDR_WE/SDR_RD stable while SDR_WAIT is high.
//   The falling edge of SDR_WAIT completes the access, and SDR_DI is valid
//   from then on.
//   Backend side: MEM_REQ is a level "valid" and is held, with MEM_WE/MEM_A/
//   MEM_DO/MEM_BE stable, until the backend answers with a one-cycle MEM_ACK
//   ("ready"). The transfer happens on the clock edge where both are high.
//   Read data on MEM_DI is valid in that same cycle.
interface s32x_sdr_responder_if;
  logic [16:0] SDR_A;
  logic [15:0] SDR_DO;
  logic        SDR_CS;
  logic [1:0]  SDR_WE;
  logic        SDR_RD;
  logic        SDR_WAIT;
  logic [15:0] SDR_DI;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [16:0] MEM_A;
  logic [15:0] MEM_DO;
  logic [1:0]  MEM_BE;
  logic [15:0] MEM_DI;
  logic        MEM_ACK;

  // Responder view
  modport slave (
    input  SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD, MEM_DI, MEM_ACK,
    output SDR_WAIT, SDR_DI, MEM_REQ, MEM_WE, MEM_A, MEM_DO, MEM_BE
  );

  // Core + backend view
  modport master (
    output SDR_A, SDR_DO, SDR_CS, SDR_WE, SDR_RD, MEM_DI, MEM_ACK,
    input  SDR_WAIT, SDR_DI, MEM_REQ, MEM_WE, MEM_A, MEM_DO, MEM_BE
  );
endinterface

// File: rtl/s32x_sdr_responder.sv
// Memory-side responder for the 32X SH-2 SDRAM port. Each core access raises
// SDR_WAIT and is turned into a backend req/ack transfer. An optional
// one-word write-through read cache lets repeated reads skip the backend.
module s32x_sdr_responder #(
  parameter int MIN_WAIT  = 2,
  parameter bit USE_CACHE = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  s32x_sdr_responder_if.slave     bus,
  output logic [1:0]              dbg_state_o
);

  localparam int CW = $clog2(MIN_WAIT + 1);
  localparam logic [CW-1:0] HOLD_INIT = CW'(MIN_WAIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [16:0]   cap_a_q;
  logic [15:0]   cap_do_q;
  logic [1:0]    cap_we_q;
  logic          cap_rd_q;
  logic          mem_we_q;
  logic [1:0]    mem_be_q;
  logic [CW-1:0] hold_cnt_q;
  logic [15:0]   sdr_di_q;
  logic          cache_valid_q;
  logic [16:0]   cache_tag_q;
  logic [15:0]   cache_data_q;

  logic act;
  logic acc_wr;
  logic cache_hit;
  logic differs;
  logic start;
  logic mem_done;

  // A write wins when both SDR_RD and SDR_WE are set.
  assign act       = bus.SDR_CS & (bus.SDR_RD | (bus.SDR_WE != 2'b00));
  assign acc_wr    = (bus.SDR_WE != 2'b00);
  assign cache_hit = USE_CACHE && !acc_wr && cache_valid_q && (cache_tag_q == bus.SDR_A);
  // A strobe that stays active but changes its signature is a new access.
  assign differs   = (bus.SDR_A != cap_a_q) | (bus.SDR_WE != cap_we_q) | (bus.SDR_RD != cap_rd_q);
  assign start     = act && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && differs));
  // MEM_ACK only counts while a request is outstanding.
  assign mem_done  = (state_q == ST_REQ) && bus.MEM_ACK;

  assign bus.MEM_A  = cap_a_q;
  assign bus.MEM_DO = cap_do_q;
  assign bus.MEM_WE = mem_we_q;
  assign bus.MEM_BE = mem_be_q;
  assign bus.SDR_DI = sdr_di_q;
  assign dbg_state_o = state_q;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = cache_hit ? ST_HOLD : ST_REQ;
      ST_REQ:  if (bus.MEM_ACK) state_d = ST_HOLD;
      ST_HOLD: if (hold_cnt_q == '0) state_d = ST_DONE;
      ST_DONE: begin
        if (start)     state_d = cache_hit ? ST_HOLD : ST_REQ;
        else if (!act) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state, so reset clears them without waiting for a clock.
  always_comb begin
    bus.SDR_WAIT = (state_q == ST_REQ) || (state_q == ST_HOLD);
    bus.MEM_REQ  = (state_q == ST_REQ);
  end

  // Capture registers, minimum-wait counter and read-data register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_a_q    <= '0;
      cap_do_q   <= '0;
      cap_we_q   <= '0;
      cap_rd_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      hold_cnt_q <= '0;
      sdr_di_q   <= '0;
    end else begin
      if (start) begin
        cap_a_q    <= bus.SDR_A;
        cap_do_q   <= bus.SDR_DO;
        cap_we_q   <= bus.SDR_WE;
        cap_rd_q   <= bus.SDR_RD;
        mem_we_q   <= acc_wr;
        mem_be_q   <= acc_wr ? bus.SDR_WE : 2'b11;
        hold_cnt_q <= HOLD_INIT;
        if (cache_hit) sdr_di_q <= cache_data_q;
      end else if (((state_q == ST_REQ) || (state_q == ST_HOLD)) && (hold_cnt_q != '0)) begin
        hold_cnt_q <= hold_cnt_q - CW'(1);
      end
      if (mem_done && !mem_we_q) sdr_di_q <= bus.MEM_DI;
    end
  end

  // One-entry cache: reads allocate, writes only update a matching valid entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else if (USE_CACHE && mem_done) begin
      if (!mem_we_q) begin
        cache_valid_q <= 1'b1;
        cache_tag_q   <= cap_a_q;
        cache_data_q  <= bus.MEM_DI;
      end else if (cache_valid_q && (cache_tag_q == cap_a_q)) begin
        if (cap_we_q[1]) cache_data_q[15:8] <= cap_do_q[15:8];
        if (cap_we_q[0]) cache_data_q[7:0]  <= cap_do_q[7:0];
      end
    end
  end

endmodule
